// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: MDU op encodings and default latencies shared by the MDU files.
package mdu_unit_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } mdu_op_e;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  function automatic logic is_arith(input logic [2:0] op);
    return !op[2];
  endfunction
endpackage

// File: rtl/mdu_unit_latency_counter.sv
// mdu_unit_latency_counter: loadable down-counter that models op latency and flags the commit edge.
module mdu_unit_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             cancel,
  input  logic [CNT_W-1:0] n,
  output logic             busy,
  output logic             commit
);
  logic [CNT_W-1:0] cnt;
  assign busy = cnt != '0;
  assign commit = cnt == CNT_W'(1) && !cancel;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (cancel) cnt <= '0;
    else if (load) cnt <= n;
    else if (busy) cnt <= cnt - CNT_W'(1);
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: HI/LO registers plus fixed-latency mult/multu/div/divu with mfhi/mflo/mthi/mtlo access.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             we,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] a_q, b_q, ua, ub, uq, ur, qv, rv;
  logic [2*WIDTH-1:0] prod;
  logic [2:0] op_q;
  logic accept, commit, is_signed, neg_a, neg_b;
  assign accept = start && !busy && !cancel && is_arith(op);
  mdu_unit_latency_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .cancel(cancel),
    .n(op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)),
    .busy(busy),
    .commit(commit)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      op_q <= op;
    end
  // Signed divide runs on magnitudes so the most-negative / -1 case wraps instead of overflowing.
  always_comb begin
    is_signed = op_q == OP_MULT || op_q == OP_DIV;
    neg_a = is_signed && a_q[WIDTH-1];
    neg_b = is_signed && b_q[WIDTH-1];
    prod = {{WIDTH{neg_a}}, a_q} * {{WIDTH{neg_b}}, b_q};
    ua = neg_a ? -a_q : a_q;
    ub = neg_b ? -b_q : b_q;
    uq = ub == '0 ? '0 : ua / ub;
    ur = ub == '0 ? '0 : ua % ub;
    qv = (neg_a ^ neg_b) ? -uq : uq;
    rv = neg_a ? -ur : ur;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (!op_q[1]) {hi, lo} <= prod;
      else if (b_q != '0) begin
        hi <= rv;
        lo <= qv;
      end
    end else if (!busy && !start && we) begin
      if (op == OP_MTHI) hi <= a;
      if (op == OP_MTLO) lo <= a;
    end
  assign rd_data = op == OP_MFHI ? hi : op == OP_MFLO ? lo : '0;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors with hand-computed HI/LO, busy-length and abort/reset checks.
module tb_mdu_unit;
  import mdu_unit_pkg::*;
  logic clk = 0, reset = 1, start = 0, we = 0, cancel = 0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic busy;
  logic [31:0] hi, lo, rd_data;
  int vectors = 0, errors = 0, n;

  mdu_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .we(we), .cancel(cancel),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1;
    tick;
    start = 0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick;
    end
  endtask

  initial begin
    tick; tick;
    reset = 0;
    tick;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    launch(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy_len", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_busy_len", n, 32'd5);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_busy_len", n, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    launch(OP_DIVU, 32'd7, 32'd0);
    chk("divu0_busy_len", n, 32'd10);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);

    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    launch(OP_DIVU, 32'd100, 32'd7);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    op = OP_MTHI; a = 32'h1234; we = 1;
    tick;
    we = 0; op = OP_MFHI;
    #1;
    chk("mthi_hi", hi, 32'h1234);
    chk("mfhi_rd", rd_data, 32'h1234);
    op = OP_MFLO;
    #1;
    chk("mflo_rd", rd_data, 32'd14);
    op = OP_MULT;
    #1;
    chk("rd_other", rd_data, 32'd0);

    op = OP_MULT; a = 32'd3; b = 32'd4; start = 1;
    tick;
    start = 0; n = 0;
    while (busy && n < 50) begin
      we = (n == 1);
      start = (n == 2);
      op = n == 1 ? OP_MTLO : n == 2 ? OP_DIV : OP_MULT;
      a = n == 1 ? 32'hDEAD : 32'd100;
      b = 32'd7;
      n++;
      tick;
      if (n == 2) chk("mtlo_busy_lo", lo, 32'd14);
    end
    we = 0; start = 0;
    chk("restart_busy_len", n, 32'd5);
    chk("restart_hi", hi, 32'd0);
    chk("restart_lo", lo, 32'd12);

    op = OP_MULT; a = 32'd5; b = 32'd5; start = 1;
    tick;
    start = 0;
    tick; tick;
    cancel = 1;
    tick;
    cancel = 0;
    chk("cancel_busy", {31'b0, busy}, 32'd0);
    tick; tick; tick; tick;
    chk("cancel_hi", hi, 32'd0);
    chk("cancel_lo", lo, 32'd12);

    op = OP_MULT; a = 32'd2; b = 32'd3; start = 1;
    tick;
    start = 0;
    tick; tick; tick; tick;
    cancel = 1;
    tick;
    cancel = 0;
    chk("cancel_commit_busy", {31'b0, busy}, 32'd0);
    chk("cancel_commit_lo", lo, 32'd12);

    op = OP_MTHI; a = 32'h5555; we = 1; start = 1;
    tick;
    we = 0; start = 0;
    chk("start_we_hi", hi, 32'd0);
    chk("start_mthi_busy", {31'b0, busy}, 32'd0);

    op = OP_MFLO; start = 1;
    tick;
    start = 0;
    chk("start_mflo_busy", {31'b0, busy}, 32'd0);

    op = OP_MTHI; a = 32'h55; we = 1;
    tick;
    we = 0;
    op = OP_DIV; a = 32'd100; b = 32'd7; start = 1;
    tick;
    start = 0;
    tick; tick;
    #2 reset = 1;
    #1;
    chk("areset_busy", {31'b0, busy}, 32'd0);
    chk("areset_hi", hi, 32'd0);
    chk("areset_lo", lo, 32'd0);
    tick;
    reset = 0;
    repeat (12) tick;
    chk("post_reset_busy", {31'b0, busy}, 32'd0);
    chk("post_reset_lo", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core.
- Holds the architectural HI/LO registers and executes mult/multu/div/divu over a fixed, parameter-set number of cycles.
- Asserts busy so the hazard unit can stall any following MDU instruction.
- Serves mfhi/mflo reads and mthi/mtlo writes, using the decoder's Start/MDUop outputs.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (min 1).
- DIV_CYCLES, 10, busy cycles for div/divu (min 1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch the arithmetic op selected by op (one-cycle pulse from decoder)
- op  in  3  MDU op code, package encoding
- we  in  1  write-enable qualifier for mthi/mtlo
- cancel  in  1  abort any in-flight op (exception/flush)
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand
- busy  out  1  arithmetic op in progress
- hi  out  WIDTH  current HI
- lo  out  WIDTH  current LO
- rd_data  out  WIDTH  hi when op==MFHI, lo when op==MFLO, else 0 (combinational)

Behaviour:
- Reset (async, active-high): hi=0, lo=0, busy=0, counter=0, operand latches=0. Reset during an op discards it.
- Idle accept: start=1 while busy=0 and cancel=0, with op in {MULT, MULTU, DIV, DIVU}:
  - a, b and op are latched at that edge.
  - counter loads N (MULT_CYCLES or DIV_CYCLES).
  - busy rises on the next cycle.
- Busy phase:
  - busy stays 1 for exactly N cycles after the start cycle; the counter decrements each edge.
  - At the edge where the counter goes 1->0, HI/LO commit and busy falls.
  - New HI/LO are visible in the first cycle with busy=0.
- Arithmetic, computed from the latched operands:
  - mult: {hi,lo} = signed a*b, 2*WIDTH product.
  - multu: same, unsigned.
  - div: lo = a/b truncated toward zero; hi = remainder, same sign as a.
  - divu: unsigned quotient and remainder.
- Divide boundaries:
  - b==0: HI and LO left unchanged; busy still runs the full DIV_CYCLES.
  - div with a = most negative value and b = -1: lo = most negative value, hi = 0 (wrap, no trap).
- Ignored requests (no state change, no error flag; the hazard unit must stall instead):
  - start while busy=1.
  - start with op in {MFHI, MFLO, MTHI, MTLO}.
- mthi/mtlo:
  - we=1, op=MTHI: hi <= a at the edge. MTLO: lo <= a.
  - Honoured only when busy=0 and start=0; ignored while busy=1.
- mfhi/mflo: rd_data is combinational from hi/lo. A read while busy=1 returns the stale value; the stall is the pipeline's responsibility.
- cancel:
  - cancel=1 clears busy and the counter at the edge; HI/LO keep their pre-op values.
  - cancel has priority over start and over a same-edge commit (the op is lost).
- Simultaneous start with we=1: start wins, the write is dropped.
- No internal iterative datapath is required: the result may be computed at the commit edge from latched operands, with the counter modelling latency.

Decomposition:
- Shared package/header mdu_defs: op encodings MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MFHI=3'd4, MFLO=3'd5, MTHI=3'd6, MTLO=3'd7; default cycle counts.
- Optional sub-module mdu_latency_counter: load/decrement/zero-detect, producing busy and commit.

Test Plan:
- mult, a=32'hFFFF_FFFE (-2), b=3, MULT_CYCLES=5 -> busy high exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- multu, a=32'hFFFF_FFFF, b=2 -> hi=1, lo=32'hFFFF_FFFE after 5 busy cycles.
- div, a=-7, b=2 -> after 10 busy cycles lo=-3 (32'hFFFF_FFFD), hi=-1. Then divu a=7, b=0 -> hi/lo unchanged, busy still 10 cycles.
- div, a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
- Ignored and dropped requests:
  - mthi a=32'h1234 while idle -> hi=32'h1234 next cycle; op=MFHI gives rd_data=32'h1234.
  - mtlo issued while busy -> lo unchanged.
  - second start while busy -> ignored, busy length unchanged.
- Abort and reset:
  - cancel asserted in 3rd busy cycle of a mult -> busy=0 next cycle, hi/lo equal pre-op values.
  - reset asserted mid-div (asynchronously, between edges) -> busy, hi and lo drop to 0 immediately.
